// File: rtl/mmu_pte_mem_resp.sv
// Fixed-latency, in-order memory responder for the MMU page-table walker.
// PTEs come from a small write-loaded table snapshotted when a request is accepted.
module mmu_pte_mem_resp #(
  parameter int PA_W   = 48,
  parameter int PTE_W  = 64,
  parameter int DEPTH  = 4,
  parameter int LAT    = 8,
  parameter int TBL_AW = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_pma,
  input  logic [PA_W-1:0]        req_ppa,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_err,
  output logic [PTE_W-1:0]       resp_pte,
  input  logic                   wr_valid,
  input  logic [TBL_AW-1:0]      wr_idx,
  input  logic [PTE_W-1:0]       wr_data,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(LAT + 1);

  logic [PTE_W-1:0]  pte_table [1 << TBL_AW];
  logic [PTE_W-1:0]  rd_data_reg;

  logic [CW-1:0]     count_reg;
  logic [PW-1:0]     head_reg;
  logic [PW-1:0]     tail_reg;
  logic [DEPTH-1:0]  occ_reg;
  logic [DEPTH-1:0]  done_reg;
  logic [DEPTH-1:0]  err_reg;
  logic [TW-1:0]     timer_reg [DEPTH];
  logic [PTE_W-1:0]  pte_reg [DEPTH];

  logic              fill_reg;
  logic              fill_zero_reg;
  logic [PW-1:0]     fill_slot_reg;

  logic              accept;
  logic              pop;
  logic              req_err;
  logic [TBL_AW-1:0] req_idx;

  assign req_idx   = req_ppa[TBL_AW+2:3];
  assign req_err   = ~((req_ppa[PA_W-1:TBL_AW+3] == '0) & (req_ppa[2:0] == 3'b000));
  assign req_ready = (count_reg < CW'(DEPTH));
  assign accept    = req_valid & req_ready;

  assign resp_valid  = (count_reg != '0) & done_reg[head_reg];
  assign pop         = resp_valid & resp_ready;
  assign resp_err    = resp_valid & err_reg[head_reg];
  assign resp_pte    = resp_valid ? pte_reg[head_reg] : '0;
  assign outstanding = count_reg;

  // Registered read issued on accept; a same-cycle write to that slot lands after the read.
  always_ff @(posedge clock) begin
    if (wr_valid) pte_table[wr_idx] <= wr_data;
    if (accept)   rd_data_reg <= pte_table[req_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      if (accept) tail_reg <= tail_reg + PW'(1);
      if (pop)    head_reg <= head_reg + PW'(1);
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The table word arrives one cycle after accept; LAT >= 1 guarantees it lands before the entry is due.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_reg      <= 1'b0;
      fill_zero_reg <= 1'b0;
      fill_slot_reg <= '0;
    end else begin
      fill_reg      <= accept;
      fill_zero_reg <= req_pma | req_err;
      fill_slot_reg <= tail_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_reg) pte_reg[fill_slot_reg] <= fill_zero_reg ? '0 : rd_data_reg;
  end

  // done is set on the edge after the timer reaches zero, so a response is visible LAT edges after accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_reg  <= '0;
      done_reg <= '0;
      err_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) timer_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (tail_reg == PW'(i))) begin
          occ_reg[i]   <= 1'b1;
          done_reg[i]  <= 1'b0;
          err_reg[i]   <= req_err;
          timer_reg[i] <= TW'(LAT - 1);
        end else if (pop && (head_reg == PW'(i))) begin
          occ_reg[i]  <= 1'b0;
          done_reg[i] <= 1'b0;
        end else if (occ_reg[i]) begin
          if (timer_reg[i] == '0) done_reg[i] <= 1'b1;
          else                    timer_reg[i] <= timer_reg[i] - TW'(1);
        end
      end
    end
  end

  a_resp_stable : assert property (@(posedge clock) disable iff (!reset)
    (resp_valid && !resp_ready) |=> ($stable(resp_err) && $stable(resp_pte)));

  a_count_max : assert property (@(posedge clock) disable iff (!reset)
    count_reg <= CW'(DEPTH));

endmodule

// File: tb/tb_mmu_pte_mem_resp.sv
// Bench for mmu_pte_mem_resp: directed vector table, hand sequences and a random stream,
// all checked against a queue-based model of accept time, due time and table lookup.
module tb_mmu_pte_mem_resp;
  localparam int PA_W = 48, PTE_W = 64, DEPTH = 4, LAT = 8, TBL_AW = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid, req_ready, req_pma;
  logic [PA_W-1:0]   req_ppa;
  logic              resp_valid, resp_ready, resp_err;
  logic [PTE_W-1:0]  resp_pte;
  logic              wr_valid;
  logic [TBL_AW-1:0] wr_idx;
  logic [PTE_W-1:0]  wr_data;
  logic [2:0]        outstanding;

  always #5 clock = ~clock;

  mmu_pte_mem_resp #(.PA_W(PA_W), .PTE_W(PTE_W), .DEPTH(DEPTH), .LAT(LAT), .TBL_AW(TBL_AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pma(req_pma), .req_ppa(req_ppa),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err), .resp_pte(resp_pte),
    .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data), .outstanding(outstanding)
  );

  typedef struct { logic err; logic [63:0] pte; longint due; } exp_t;
  typedef struct { logic pma; logic [47:0] ppa; } req_t;
  typedef struct { logic pma; logic [47:0] ppa; logic err; logic [63:0] pte; } vec_t;

  exp_t        mq[$];
  req_t        sendq[$];
  logic [63:0] mtab [1024];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response straight from the address rules: 1024 slots of 8 bytes from address 0.
  function automatic exp_t lookup(req_t r);
    exp_t e;
    bit in_range, aligned;
    in_range = (r.ppa < 48'(1024 * 8));
    aligned  = (r.ppa % 8) == 0;
    e.err = !(in_range && aligned);
    e.pte = (r.pma || e.err) ? 64'h0 : mtab[int'((r.ppa / 8) % 1024)];
    e.due = 0;
    return e;
  endfunction

  task automatic drive();
    req_valid = (sendq.size() > 0);
    req_pma   = req_valid ? sendq[0].pma : 1'b0;
    req_ppa   = req_valid ? sendq[0].ppa : '0;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (mq.size() > 0) && (mq[0].due <= cyc);
    chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
    chk("resp_valid", 64'(resp_valid), 64'(ev));
    chk("outstanding", 64'(outstanding), 64'(mq.size()));
    if (ev) begin
      chk("resp_err", 64'(resp_err), 64'(mq[0].err));
      chk("resp_pte", resp_pte, mq[0].pte);
    end
  endtask

  task automatic step();
    bit   acc, pop;
    exp_t e;
    acc = reset && req_valid && (mq.size() < DEPTH);
    pop = reset && resp_ready && (mq.size() > 0) && (mq[0].due <= cyc);
    if (acc) e = lookup(sendq[0]);
    @(posedge clock);
    cyc++;
    if (!reset) mq.delete();
    if (pop) begin
      $display("cycle %0d resp err=%0d pte=0x%0h", cyc, mq[0].err, mq[0].pte);
      void'(mq.pop_front());
    end
    if (acc) begin
      e.due = cyc + LAT;
      mq.push_back(e);
      $display("cycle %0d req  pma=%0d ppa=0x%0h", cyc, sendq[0].pma, sendq[0].ppa);
      void'(sendq.pop_front());
    end
    if (wr_valid) mtab[wr_idx] = wr_data;
    #1;
    check_outputs();
    wr_valid = 1'b0;
    drive();
  endtask

  task automatic write_tbl(int idx, logic [63:0] data);
    wr_valid = 1'b1;
    wr_idx   = TBL_AW'(idx);
    wr_data  = data;
    step();
  endtask

  task automatic wait_resp(string name, logic err, logic [63:0] pte);
    int n = 0;
    while (!resp_valid && n < 40) begin step(); n++; end
    chk({name, "_seen"}, 64'(resp_valid), 64'(1));
    chk({name, "_err"}, 64'(resp_err), 64'(err));
    chk({name, "_pte"}, resp_pte, pte);
    step();
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((mq.size() > 0 || sendq.size() > 0) && n < budget) begin step(); n++; end
    chk("drain", 64'(mq.size() + sendq.size()), 64'(0));
    chk("drain_outstanding", 64'(outstanding), 64'(0));
  endtask

  vec_t vt[7];

  initial begin
    longint t0;
    int     n;
    logic [63:0] held;
    int     seed_dummy;

    req_valid = 0; req_pma = 0; req_ppa = '0; resp_ready = 1;
    wr_valid = 0; wr_idx = '0; wr_data = '0;
    for (int i = 0; i < 1024; i++) mtab[i] = 64'h0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_err", 64'(resp_err), 64'(0));
    chk("rst_resp_pte", resp_pte, 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    reset = 1'b1;

    for (int i = 0; i < 1024; i++) write_tbl(i, 64'h0);
    write_tbl(5, 64'h0000_0000_1234_5001);
    write_tbl(0, 64'h0000_0000_0BAD_F00D);
    write_tbl(1023, 64'hFEED_0000_0000_BEEF);

    vt[0] = '{1'b0, 48'h28, 1'b0, 64'h0000_0000_1234_5001};
    vt[1] = '{1'b0, 48'h2C, 1'b1, 64'h0};
    vt[2] = '{1'b0, 48'h2000, 1'b1, 64'h0};
    vt[3] = '{1'b1, 48'h28, 1'b0, 64'h0};
    vt[4] = '{1'b0, 48'h0, 1'b0, 64'h0000_0000_0BAD_F00D};
    vt[5] = '{1'b0, 48'h1FF8, 1'b0, 64'hFEED_0000_0000_BEEF};
    vt[6] = '{1'b0, 48'h8000_0000_0000, 1'b1, 64'h0};

    for (int i = 0; i < 7; i++) begin
      sendq.push_back('{vt[i].pma, vt[i].ppa});
      drive();
      step();
      t0 = cyc;
      n = 0;
      while (!resp_valid && n < 30) begin step(); n++; end
      chk($sformatf("vec%0d_latency", i), 64'(cyc - t0), 64'(LAT));
      chk($sformatf("vec%0d_err", i), 64'(resp_err), 64'(vt[i].err));
      chk($sformatf("vec%0d_pte", i), resp_pte, vt[i].pte);
      step();
    end

    // Misaligned and out-of-range both in flight, answered in order.
    sendq.push_back('{1'b0, 48'h2C});
    sendq.push_back('{1'b0, 48'h2000});
    sendq.push_back('{1'b0, 48'h28});
    drive();
    wait_resp("order_a", 1'b1, 64'h0);
    wait_resp("order_b", 1'b1, 64'h0);
    wait_resp("order_c", 1'b0, 64'h0000_0000_1234_5001);

    // Same-cycle write and accept to slot 5: old data first, new data next.
    wr_valid = 1'b1; wr_idx = TBL_AW'(5); wr_data = 64'hAA;
    sendq.push_back('{1'b0, 48'h28});
    drive();
    step();
    sendq.push_back('{1'b0, 48'h28});
    drive();
    wait_resp("rbw_old", 1'b0, 64'h0000_0000_1234_5001);
    wait_resp("rbw_new", 1'b0, 64'hAA);

    // Fill the queue with responses stalled.
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) sendq.push_back('{1'b0, 48'(i * 8)});
    drive();
    repeat (6) step();
    chk("full_outstanding", 64'(outstanding), 64'(4));
    chk("full_req_ready", 64'(req_ready), 64'(0));
    n = 0;
    while (!resp_valid && n < 20) begin step(); n++; end
    held = resp_pte;
    repeat (3) step();
    chk("head_stable", resp_pte, held);
    chk("head_value", resp_pte, 64'h0000_0000_0BAD_F00D);
    resp_ready = 1'b1;
    wait_idle(100);

    // Random stream over slots 0..31 with random backpressure and table writes.
    seed_dummy = $urandom(0);
    for (int i = 0; i < 32; i++) write_tbl(i, {$urandom, $urandom});
    for (int i = 0; i < 32; i++) sendq.push_back('{1'b0, 48'(i * 8)});
    drive();
    n = 0;
    while ((mq.size() > 0 || sendq.size() > 0) && n < 2000) begin
      resp_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b1;
        wr_idx   = TBL_AW'($urandom_range(0, 40));
        wr_data  = {$urandom, $urandom};
      end
      step();
      n++;
    end
    resp_ready = 1'b1;
    wait_idle(100);

    // Reset with three requests outstanding.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) sendq.push_back('{1'b0, 48'(i * 8)});
    drive();
    n = 0;
    while (!resp_valid && n < 30) begin step(); n++; end
    chk("pre_rst_valid", 64'(resp_valid), 64'(1));
    reset = 1'b0;
    mq.delete();
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_outstanding", 64'(outstanding), 64'(0));
    repeat (2) step();
    reset = 1'b1;
    resp_ready = 1'b1;
    repeat (12) step();
    sendq.push_back('{1'b0, 48'h28});
    drive();
    step();
    t0 = cyc;
    n = 0;
    while (!resp_valid && n < 30) begin step(); n++; end
    chk("post_rst_latency", 64'(cyc - t0), 64'(LAT));
    chk("post_rst_pte", resp_pte, mtab[5]);
    step();
    wait_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
